// File: rtl/ofdm_pkg.sv
// Shared constants for the OFDM symbol sequencer: FSM encoding, step modes,
// and table-address helpers.
package ofdm_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CP   = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_STEP1 = 1'b0;
  localparam logic MODE_STEP2 = 1'b1;

  // First prefix address; folds to 0 when the prefix is disabled.
  function automatic logic [31:0] cp_base_f(input int unsigned aw, input int unsigned cp_len);
    logic [31:0] n;
    n = 32'd1 << aw;
    cp_base_f = (n - cp_len) & (n - 32'd1);
  endfunction

  function automatic logic [31:0] last_f(input int unsigned aw, input logic mode);
    last_f = (32'd1 << aw) - ((mode == MODE_STEP2) ? 32'd2 : 32'd1);
  endfunction

endpackage

// File: rtl/ofdm_addr_gen.sv
// Loadable address register that advances by 1 or 2 (mod 2^ADDR_WIDTH) and
// flags when it sits on the last address reachable for the current step.
module ofdm_addr_gen
  import ofdm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  adv,
  input  logic                  mode,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wrap
);

  localparam logic [ADDR_WIDTH-1:0] LAST1 = ADDR_WIDTH'(last_f(ADDR_WIDTH, MODE_STEP1));
  localparam logic [ADDR_WIDTH-1:0] LAST2 = ADDR_WIDTH'(last_f(ADDR_WIDTH, MODE_STEP2));

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, step;

  assign step = (mode == MODE_STEP2) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
  assign wrap = (addr_q == ((mode == MODE_STEP2) ? LAST2 : LAST1));
  assign addr = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (load)     addr_d = load_addr;
    else if (adv) addr_d = addr_q + step;
  end

  always_ff @(posedge clk) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end

endmodule

// File: rtl/ofdm_symbol_sequencer.sv
// Burst controller: streams CP + body ROM addresses per OFDM symbol with
// backpressure, and frames the ROM output (valid/sop/eop) one cycle later.
module ofdm_symbol_sequencer
  import ofdm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int CP_LEN     = 512,
  parameter int NSYM_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mod_switch,
  input  logic [NSYM_WIDTH-1:0] num_symbols,
  input  logic                  ready_in,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rd_en,
  output logic                  valid_out,
  output logic                  sop,
  output logic                  eop,
  output logic [NSYM_WIDTH-1:0] sym_idx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] CP_BASE    = ADDR_WIDTH'(cp_base_f(ADDR_WIDTH, CP_LEN));
  localparam logic                  HAS_CP     = (CP_LEN != 0);
  localparam logic [1:0]            ST_ENTRY   = HAS_CP ? ST_CP : ST_BODY;
  localparam logic [ADDR_WIDTH-1:0] ENTRY_ADDR = HAS_CP ? CP_BASE : '0;

  logic [1:0]            state_q, state_d;
  logic                  mode_q, mode_d;
  logic [NSYM_WIDTH-1:0] count_q, count_d, sym_q, sym_d;
  logic                  valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic                  load, adv, wrap, in_burst, rd, first_rd;
  logic [ADDR_WIDTH-1:0] load_addr, cur_addr;

  ofdm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_addr (load_addr),
    .adv       (adv),
    .mode      (mode_q),
    .addr      (cur_addr),
    .wrap      (wrap)
  );

  assign in_burst = (state_q == ST_CP) || (state_q == ST_BODY);
  assign rd       = ready_in && in_burst;
  // Entry address is visited exactly once per symbol, so it marks the symbol start.
  assign first_rd = HAS_CP ? ((state_q == ST_CP)   && (cur_addr == CP_BASE))
                           : ((state_q == ST_BODY) && (cur_addr == '0));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    sym_d     = sym_q;
    load      = 1'b0;
    load_addr = ENTRY_ADDR;
    adv       = 1'b0;
    valid_d   = rd;
    sop_d     = rd && first_rd;
    eop_d     = rd && (state_q == ST_BODY) && wrap;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_symbols == '0) begin
            state_d = ST_DONE;
          end else begin
            mode_d  = mod_switch;
            count_d = num_symbols;
            sym_d   = '0;
            load    = 1'b1;
            state_d = ST_ENTRY;
          end
        end
      end
      ST_CP: begin
        if (rd) begin
          if (wrap) begin
            state_d   = ST_BODY;
            load      = 1'b1;
            load_addr = '0;
          end else begin
            adv = 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (rd) begin
          if (!wrap) begin
            adv = 1'b1;
          end else if (sym_q == count_q - NSYM_WIDTH'(1)) begin
            state_d = ST_DONE;
          end else begin
            sym_d   = sym_q + NSYM_WIDTH'(1);
            load    = 1'b1;
            state_d = ST_ENTRY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_STEP1;
      count_q <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign addr      = cur_addr;
  assign rd_en     = rd;
  assign valid_out = valid_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign sym_idx   = sym_q;
  assign busy      = in_burst;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Directed/randomized bench for ofdm_symbol_sequencer: a CP_LEN=4 and a CP_LEN=0
// instance (N=16) checked against per-burst address/framing queues.
module tb_ofdm_symbol_sequencer;

  localparam int AW = 4;
  localparam int NW = 8;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic reset, start, start_z, mod_switch, ready_in;
  logic [NW-1:0] num_symbols;

  logic [AW-1:0] addr, addr_z;
  logic [NW-1:0] sym_idx, sym_idx_z;
  logic rd_en, valid_out, sop, eop, busy, done;
  logic rd_en_z, valid_out_z, sop_z, eop_z, busy_z, done_z;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ofdm_symbol_sequencer #(.ADDR_WIDTH(AW), .CP_LEN(4), .NSYM_WIDTH(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .mod_switch(mod_switch),
    .num_symbols(num_symbols), .ready_in(ready_in), .addr(addr), .rd_en(rd_en),
    .valid_out(valid_out), .sop(sop), .eop(eop), .sym_idx(sym_idx), .busy(busy), .done(done)
  );

  ofdm_symbol_sequencer #(.ADDR_WIDTH(AW), .CP_LEN(0), .NSYM_WIDTH(NW)) dut_z (
    .clk(clk), .reset(reset), .start(start_z), .mod_switch(mod_switch),
    .num_symbols(num_symbols), .ready_in(ready_in), .addr(addr_z), .rd_en(rd_en_z),
    .valid_out(valid_out_z), .sop(sop_z), .eop(eop_z), .sym_idx(sym_idx_z), .busy(busy_z),
    .done(done_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // z selects the CP_LEN=0 instance; poke fires a start while busy and toggles mod_switch.
  task automatic run_burst(input bit z, input logic mode, input int nsym, input bit rnd,
                           input bit poke);
    int ea[$]; int esym[$]; bit es[$]; bit ee[$];
    int cpl, step, rd_i, v_i, cyc;
    bit fin, prev_stall;
    logic [AW-1:0] prev_addr, o_addr;
    logic [NW-1:0] o_sym;
    logic o_rd, o_v, o_sop, o_eop, o_busy, o_done;
    cpl  = z ? 0 : 4;
    step = mode ? 2 : 1;
    for (int s = 0; s < nsym; s++) begin
      for (int a = N - cpl; a < N; a += step) begin
        ea.push_back(a); esym.push_back(s); es.push_back(a == N - cpl); ee.push_back(1'b0);
      end
      for (int a = 0; a < N; a += step) begin
        ea.push_back(a); esym.push_back(s);
        es.push_back(cpl == 0 && a == 0); ee.push_back(a + step >= N);
      end
    end
    @(negedge clk);
    mod_switch  = mode;
    num_symbols = NW'(nsym);
    ready_in    = 1'b1;
    if (z) start_z = 1'b1; else start = 1'b1;
    rd_i = 0; v_i = 0; cyc = 0; fin = 1'b0; prev_stall = 1'b0; prev_addr = '0;
    while (!fin && cyc < 1000) begin
      @(negedge clk);
      start = 1'b0; start_z = 1'b0;
      ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        if (cyc == 5) begin
          num_symbols = NW'(nsym + 3);
          if (z) start_z = 1'b1; else start = 1'b1;
        end
        mod_switch = ~mod_switch;
      end
      #1;
      o_addr = z ? addr_z : addr;          o_sym  = z ? sym_idx_z : sym_idx;
      o_rd   = z ? rd_en_z : rd_en;        o_v    = z ? valid_out_z : valid_out;
      o_sop  = z ? sop_z : sop;            o_eop  = z ? eop_z : eop;
      o_busy = z ? busy_z : busy;          o_done = z ? done_z : done;
      if (prev_stall && o_busy) chk("stall_hold_addr", o_addr, prev_addr);
      if (o_rd) begin
        if (rd_i < ea.size()) begin
          chk("addr", o_addr, ea[rd_i]);
          chk("sym_idx", o_sym, esym[rd_i]);
        end else begin
          chk("extra_read", rd_i, ea.size());
        end
        rd_i++;
      end
      if (o_v) begin
        if (v_i < es.size()) begin
          chk("sop", o_sop, es[v_i]);
          chk("eop", o_eop, ee[v_i]);
        end
        v_i++;
      end else begin
        chk("sop_no_valid", o_sop, 0);
        chk("eop_no_valid", o_eop, 0);
      end
      if (o_done) begin
        fin = 1'b1;
        chk("reads_at_done", rd_i, ea.size());
        if (nsym > 0) chk("done_with_last_eop", {o_v, o_eop}, 2'b11);
      end
      prev_stall = o_busy && !o_rd;
      prev_addr  = o_addr;
      cyc++;
    end
    chk("burst_done_seen", fin, 1);
    chk("valid_count", v_i, es.size());
    @(negedge clk);
    #1;
    chk("done_single_pulse", z ? done_z : done, 0);
    chk("idle_after_done", z ? busy_z : busy, 0);
  endtask

  task automatic reset_mid();
    int reads, cyc;
    bit hit;
    reads = 0; cyc = 0; hit = 1'b0;
    @(negedge clk);
    mod_switch = 1'b0; num_symbols = NW'(2); ready_in = 1'b1; start = 1'b1;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (rd_en && sym_idx == NW'(1)) begin
        reads++;
        if (reads == 7) hit = 1'b1;
      end
      cyc++;
    end
    chk("reset_point_reached", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_addr", addr, 0);
    chk("rst_mid_rd_en", rd_en, 0);
    chk("rst_mid_valid", valid_out, 0);
    chk("rst_mid_sop_eop", {sop, eop}, 0);
    chk("rst_mid_sym_idx", sym_idx, 0);
    chk("rst_mid_busy_done", {busy, done}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_z = 1'b0; mod_switch = 1'b0;
    num_symbols = '0; ready_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_sop_eop", {sop, eop}, 0);
    chk("rst_sym_idx", sym_idx, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_z_addr_busy", {addr_z, busy_z, done_z, valid_out_z}, 0);
    reset = 1'b0;

    run_burst(1'b0, 1'b0, 2, 1'b0, 1'b0);
    run_burst(1'b0, 1'b1, 1, 1'b0, 1'b0);
    run_burst(1'b0, 1'b0, 3, 1'b1, 1'b0);
    run_burst(1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_burst(1'b0, 1'b1, 2, 1'b1, 1'b1);
    run_burst(1'b0, 1'b0, 2, 1'b0, 1'b1);
    reset_mid();
    run_burst(1'b0, 1'b0, 2, 1'b0, 1'b0);
    run_burst(1'b1, 1'b0, 2, 1'b0, 1'b0);
    run_burst(1'b1, 1'b1, 1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/ofdm_symbol_sequencer.md
Name: ofdm_symbol_sequencer

Overview:
- Controller that sequences the ROM address stream for a burst of OFDM symbols.
- Each symbol is a cyclic prefix (CP) of the last CP_LEN table entries, followed by the full table body.
- Address step is 1 (full-rate) or 2 (decimated). The mode is latched per burst.
- Sits between the frame control logic and the sample ROM. It honours downstream backpressure and emits packet framing (sop/eop) aligned to ROM output data.

Parameters:
- ADDR_WIDTH, 12, ROM address width; table length N = 2^ADDR_WIDTH.
- CP_LEN, 512, prefix length in table entries. Must be even and less than N. CP_LEN = 0 disables the prefix.
- NSYM_WIDTH, 8, width of the symbol-count request.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  burst request pulse; accepted only in IDLE.
- mod_switch  input  1  0 = step 1, 1 = step 2; sampled only when start is accepted.
- num_symbols  input  NSYM_WIDTH  symbols in the burst; sampled when start is accepted.
- ready_in  input  1  downstream can accept a sample this cycle.
- addr  output  ADDR_WIDTH  ROM read address (registered).
- rd_en  output  1  ROM read strobe for addr this cycle.
- valid_out  output  1  ROM data valid, equal to rd_en delayed 1 cycle.
- sop  output  1  first sample of a symbol, aligned to valid_out.
- eop  output  1  last sample of a symbol, aligned to valid_out.
- sym_idx  output  NSYM_WIDTH  index of the symbol currently being read.
- busy  output  1  high in CP or BODY.
- done  output  1  one-cycle pulse when the burst completes.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - On reset: state = IDLE; addr = 0; rd_en = 0; valid_out = 0; sop = 0; eop = 0; sym_idx = 0; busy = 0; done = 0; latched step = 1.
  - Reset mid-burst aborts the burst at the next edge and discards any in-flight valid.
- States: IDLE, CP, BODY, DONE.
- Derived values:
  - step = 2 if the latched mode is 1, else 1.
  - LAST = N - step.
  - CP_BASE = N - CP_LEN.
  - All address arithmetic is modulo N.
- IDLE:
  - start with num_symbols ≠ 0: latch mode and count; sym_idx = 0.
  - Then go to CP with addr = CP_BASE, or to BODY with addr = 0 when CP_LEN = 0.
  - start with num_symbols = 0: go to DONE directly, with no reads.
- rd_en = ready_in AND (state is CP or BODY). It is combinational from state and ready_in.
- addr and state advance only on cycles where rd_en = 1. When ready_in = 0, everything holds.
- CP state: on rd_en, if addr = LAST, go to BODY with addr = 0; otherwise addr += step.
- BODY state: on rd_en, if addr = LAST:
  - if sym_idx = count - 1, go to DONE;
  - otherwise sym_idx += 1 and go to CP with addr = CP_BASE (or BODY with addr = 0 if CP_LEN = 0).
- BODY state: on rd_en with addr ≠ LAST, addr += step.
- DONE: done = 1 for exactly one cycle, then IDLE. start in DONE is ignored.
- start while busy is ignored; a pending mode_switch change has no effect until the next accepted start.
- Per-symbol sample counts:
  - Step 1: CP_LEN + N samples.
  - Step 2: CP_LEN/2 + N/2 samples, all at even addresses.
- Output timing (1-cycle ROM latency):
  - valid_out(t+1) = rd_en(t).
  - sop(t+1) = rd_en(t) AND first CP read of the symbol (first BODY read if CP_LEN = 0).
  - eop(t+1) = rd_en(t) AND BODY read at addr = LAST.
- Throughput: with ready_in held at 1 there are no bubbles between symbols. Back-to-back sop follows eop on the next valid.

Decomposition:
- Shared package ofdm_pkg holds:
  - the state encoding (IDLE, CP, BODY, DONE);
  - the step selection constant (MODE_STEP1 = 0, MODE_STEP2 = 1);
  - the CP_BASE/LAST computation as a constant function of ADDR_WIDTH and CP_LEN.
- One sub-module is natural: ofdm_addr_gen, a loadable, stepping address register with a wrap flag. The FSM instantiates it.

Test Plan:
- Bench parameters: ADDR_WIDTH = 4, CP_LEN = 4, ready_in = 1, start with mod_switch = 0 and num_symbols = 2.
  - Required: addr sequence 12,13,14,15,0..15 repeated twice.
  - 40 valid_out pulses; sop at samples 1 and 21; eop at samples 20 and 40.
  - done is a single pulse one cycle after the final read.
- Same bench, mod_switch = 1, num_symbols = 1:
  - Required: addr 12,14,0,2,...,14 (10 reads); sop on the first valid, eop on the tenth.
- Random ready_in (about 50%) over a 3-symbol burst:
  - Required: addr sequence identical to the stall-free run; addr is unchanged on every cycle with ready_in = 0.
  - valid_out count = 60.
- Boundary cases:
  - start with num_symbols = 0: done pulses with zero rd_en.
  - start during busy: ignored; the burst length is unchanged.
  - A mod_switch toggle mid-burst has no effect on the step.
- Reset asserted at the 7th read of symbol 1:
  - Next cycle: all outputs are 0 and the state is IDLE.
  - A following start runs a full clean burst from CP_BASE.
- CP_LEN = 0 build, step 1, num_symbols = 2:
  - Required: addr 0..15 twice; sop at samples 1 and 17.
